// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath signal bundle for the multicycle ARM core.
// The control unit connects through master; the datapath connects through slave.
interface multicycle_control_unit_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] Flags;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc,
           ImmSrc, RegSrc, ALUControl, Flags, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc,
           ImmSrc, RegSrc, ALUControl, Flags, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control FSM: Moore controls registered with the state, NZCV flag register,
// and condition-code gating of PC, register-file, memory and flag writes.
module multicycle_control_unit (
  input  logic                        CLK,
  input  logic                        RST,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       srca;
    logic       next_pc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       alu_op;
    logic [1:0] srcb;
    logic [1:0] ress;
  } ctl_t;

  function automatic ctl_t moore_ctl(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.irw = 1'b1; c.next_pc = 1'b1; c.srca = 1'b1; c.srcb = 2'b10; c.ress = 2'b10;
      end
      StDecode: begin
        c.srca = 1'b1; c.srcb = 2'b10; c.ress = 2'b10;
      end
      StMemAdr: c.srcb = 2'b01;
      StMemRd:  c.adr = 1'b1;
      StMemWb:  begin c.ress = 2'b01; c.regw = 1'b1; end
      StMemWr:  begin c.adr = 1'b1; c.memw = 1'b1; end
      StExecR:  c.alu_op = 1'b1;
      StExecI:  begin c.srcb = 2'b01; c.alu_op = 1'b1; end
      StAluWb:  c.regw = 1'b1;
      StBranch: begin c.srcb = 2'b01; c.ress = 2'b10; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  ctl_t       ctl_q;
  logic [3:0] flags_q;
  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic       no_write;
  logic       cond_ex;
  logic       pcs;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (bus.Op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = bus.Funct[5] ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = bus.Funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  // Moore controls are decoded from the next state so they come straight off flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StFetch;
      ctl_q   <= moore_ctl(StFetch);
    end else begin
      state_q <= state_d;
      ctl_q   <= moore_ctl(state_d);
    end
  end

  always_comb begin
    alu_control = 2'b00;
    if (ctl_q.alu_op) begin
      case (bus.Funct[4:1])
        4'b0100: alu_control = 2'b00;
        4'b0010: alu_control = 2'b01;
        4'b0000: alu_control = 2'b10;
        4'b1100: alu_control = 2'b11;
        4'b1010: alu_control = 2'b01;
        default: alu_control = 2'b00;
      endcase
    end
  end

  // CMP is decoded from the held instruction fields, so it still blocks the write in ALUWB.
  assign no_write  = (bus.Op == 2'b00) && (bus.Funct[4:1] == 4'b1010);
  assign flag_w[1] = ctl_q.alu_op & bus.Funct[0];
  assign flag_w[0] = flag_w[1] & ~alu_control[1];

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_q <= 4'b0000;
    end else if (cond_ex && (state_q == StExecR || state_q == StExecI)) begin
      if (flag_w[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign pcs            = ((bus.Rd == 4'b1111) & ctl_q.regw) | ctl_q.branch;
  assign bus.PCWrite    = ctl_q.next_pc | (pcs & cond_ex);
  assign bus.RegWrite   = ctl_q.regw & cond_ex & ~no_write;
  assign bus.MemWrite   = ctl_q.memw & cond_ex;
  assign bus.IRWrite    = ctl_q.irw;
  assign bus.AdrSrc     = ctl_q.adr;
  assign bus.ALUSrcA    = ctl_q.srca;
  assign bus.ALUSrcB    = ctl_q.srcb;
  assign bus.ResultSrc  = ctl_q.ress;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.ALUControl = alu_control;
  assign bus.Flags      = flags_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each issued instruction pushes its expected
// per-cycle control trace; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       memw;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] ress;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluc;
    logic [3:0] flags;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       mon_exp;
  rec_t       mon_act;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] mflags   = 4'b0000;

  // ARM condition codes over {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cf;
      4'd3:    return !cf;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cf && !z;
      4'd9:    return !cf || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_ctl(input logic [5:0] f);
    case (f[4:1])
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      4'b1010: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic rec_t base(input logic [3:0] st, input logic [1:0] op, input logic [3:0] fl);
    rec_t r;
    r        = '0;
    r.state  = st;
    r.immsrc = op;
    r.regsrc = {op == 2'b01, op == 2'b10};
    r.flags  = fl;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Called with the DUT in FETCH just after a rising edge. keep>0 pushes only the first keep
  // cycles and returns in the last of them.
  task automatic issue(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] af, input int keep);
    rec_t       seq[$];
    rec_t       r;
    logic [3:0] f0, f1;
    logic       ok0, ok1;
    logic [1:0] ctl;
    int         n;
    f0  = mflags;
    f1  = f0;
    ok0 = cond_ok(cond, f0);
    r = base(4'd0, op, f0);
    r.pcw = 1'b1; r.irw = 1'b1; r.srca = 1'b1; r.srcb = 2'd2; r.ress = 2'd2;
    seq.push_back(r);
    r = base(4'd1, op, f0);
    r.srca = 1'b1; r.srcb = 2'd2; r.ress = 2'd2;
    seq.push_back(r);
    case (op)
      2'b01: begin
        r = base(4'd2, op, f0); r.srcb = 2'd1; seq.push_back(r);
        if (funct[0]) begin
          r = base(4'd3, op, f0); r.adr = 1'b1; seq.push_back(r);
          r = base(4'd4, op, f0); r.ress = 2'd1; r.regw = ok0;
          r.pcw = (rd == 4'hF) & ok0; seq.push_back(r);
        end else begin
          r = base(4'd5, op, f0); r.adr = 1'b1; r.memw = ok0; seq.push_back(r);
        end
      end
      2'b00: begin
        ctl = alu_ctl(funct);
        r = base(funct[5] ? 4'd7 : 4'd6, op, f0);
        r.srcb = funct[5] ? 2'd1 : 2'd0; r.aluc = ctl; seq.push_back(r);
        if (ok0 && funct[0]) begin
          f1[3:2] = af[3:2];
          if (!ctl[1]) f1[1:0] = af[1:0];
        end
        ok1 = cond_ok(cond, f1);
        r = base(4'd8, op, f1);
        r.regw = ok1 & (funct[4:1] != 4'b1010);
        r.pcw  = (rd == 4'hF) & ok1;
        seq.push_back(r);
      end
      2'b10: begin
        r = base(4'd9, op, f0); r.srcb = 2'd1; r.ress = 2'd2; r.pcw = ok0; seq.push_back(r);
      end
      default: ;
    endcase
    n = (keep > 0) ? keep : seq.size();
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = af;
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    repeat ((keep > 0) ? keep - 1 : n) @(posedge CLK);
    #1;
    mflags = f1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bus.State, bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc,
                 bus.ALUControl, bus.Flags};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL cycle_trace exp_state=%0d: actual=%h expected=%h",
                 mon_exp.state, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cond, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] dp_ops [5];
    dp_ops = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    #1 RST = 1'b1;
    #2;
    check("reset_state", 32'(bus.State), 32'd0);
    check("reset_flags", 32'(bus.Flags), 32'd0);
    check("reset_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("reset_irwrite", 32'(bus.IRWrite), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b0;

    issue(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, 0);   // ADD R1,R2,R3
    issue(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0);   // LDR
    issue(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, 0);   // STR
    issue(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100, 0);   // CMP R1,#0 -> Z=1
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0);   // BEQ taken
    issue(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0000, 0);   // CMP -> Z=0
    issue(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0);   // BEQ not taken
    issue(4'h1, 2'b00, 6'b001000, 4'hF, 4'b0000, 0);   // ADDNE PC, Z=0
    issue(4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100, 0);   // CMP -> Z=1
    issue(4'h1, 2'b00, 6'b001000, 4'hF, 4'b0000, 0);   // ADDNE PC, Z=1
    issue(4'hE, 2'b00, 6'b110101, 4'd0, 4'b1111, 0);   // CMP -> NZCV=1111

    // Asynchronous reset between edges while in MEMRD.
    issue(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 4);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrd_reset_state", 32'(bus.State), 32'd0);
    check("midrd_reset_flags", 32'(bus.Flags), 32'd0);
    check("midrd_reset_pcwrite", 32'(bus.PCWrite), 32'd1);
    check("midrd_reset_irwrite", 32'(bus.IRWrite), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b0;
    mflags = 4'b0000;

    for (int k = 0; k < 150; k++) begin
      cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) funct[4:1] = dp_ops[$urandom_range(0, 4)];
      rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      issue(cond, op, funct, rd, 4'($urandom), 0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
